// File: rtl/data_path_pkg.sv
// Shared widths, depths and control encodings for the 16-bit multicycle data path.
package data_path_pkg;

    localparam int DATA_W     = 16;
    localparam int REG_COUNT  = 8;
    localparam int REG_ADDR_W = 3;
    localparam int MEM_DEPTH  = 256;
    localparam int MEM_ADDR_W = 8;
    localparam int IMM_W      = 6;

    typedef enum logic [2:0] {
        ALU_AND = 3'b000,
        ALU_OR  = 3'b001,
        ALU_ADD = 3'b010,
        ALU_SUB = 3'b110,
        ALU_SLT = 3'b111
    } alu_op_e;

    typedef enum logic [1:0] {
        SRCB_REG  = 2'b00,
        SRCB_ONE  = 2'b01,
        SRCB_SIGN = 2'b10,
        SRCB_ZERO = 2'b11
    } srcb_e;

    function automatic logic [DATA_W-1:0] sign_ext(input logic [IMM_W-1:0] imm);
        return {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};
    endfunction

    function automatic logic [DATA_W-1:0] zero_ext(input logic [IMM_W-1:0] imm);
        return {{(DATA_W-IMM_W){1'b0}}, imm};
    endfunction

endpackage

// File: rtl/data_path_reg_file.sv
// 8 x 16 register file: two combinational reads, one clocked write, R0 hardwired to zero.
module reg_file
    import data_path_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic [REG_ADDR_W-1:0] ra1,
    input  logic [REG_ADDR_W-1:0] ra2,
    input  logic [REG_ADDR_W-1:0] wa,
    input  logic [DATA_W-1:0]     wd,
    output logic [DATA_W-1:0]     rd1,
    output logic [DATA_W-1:0]     rd2
);

    logic [DATA_W-1:0] regs [REG_COUNT];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < REG_COUNT; i++) begin
                regs[i] <= '0;
            end
        end else if (we && (wa != '0)) begin
            regs[wa] <= wd;
        end
    end

    // Reads see the pre-edge contents; a same-cycle write is not forwarded.
    assign rd1 = (ra1 == '0) ? '0 : regs[ra1];
    assign rd2 = (ra2 == '0) ? '0 : regs[ra2];

endmodule

// File: rtl/data_path.sv
// Multicycle 16-bit data path: unified memory, IR/MDR/A/B/ALUOut registers, ALU and PC.
module data_path
    import data_path_pkg::*;
(
    input  logic       rst,
    input  logic       clk,
    input  logic       PCEn,
    input  logic       IorD,
    input  logic       MemWrite,
    input  logic       IRWrite,
    input  logic       RegDst,
    input  logic       MemtoReg,
    input  logic       RegWrite,
    input  logic       ALUSrcA,
    input  logic [1:0] ALUSrcB,
    input  logic [2:0] ALUControl,
    input  logic       PCSrc,
    output logic [3:0] Opcode,
    output logic [2:0] Funct,
    output logic       Zero
);

    logic [DATA_W-1:0] pc, ir, mdr, a, b, aluout;
    logic [DATA_W-1:0] mem [MEM_DEPTH];
    logic [MEM_ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_rdata;
    logic [DATA_W-1:0] rd_a, rd_b;
    logic [DATA_W-1:0] srca, srcb, alu_result, pc_next, reg_wd;
    logic [REG_ADDR_W-1:0] rs, rt, rd, reg_wa;
    logic [IMM_W-1:0] imm;

    assign rs     = ir[11:9];
    assign rt     = ir[8:6];
    assign rd     = ir[5:3];
    assign imm    = ir[5:0];
    assign Opcode = ir[15:12];
    assign Funct  = ir[2:0];

    // Only the low address bits select a word; the upper bits are ignored.
    assign mem_addr  = IorD ? aluout[MEM_ADDR_W-1:0] : pc[MEM_ADDR_W-1:0];
    assign mem_rdata = mem[mem_addr];

    // Memory is never cleared, but a write is suppressed while reset is held.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
        end else if (MemWrite) begin
            mem[mem_addr] <= b;
        end
    end

    assign reg_wa = RegDst ? rd : rt;
    assign reg_wd = MemtoReg ? mdr : aluout;

    reg_file u_reg_file (
        .clk (clk),
        .rst (rst),
        .we  (RegWrite),
        .ra1 (rs),
        .ra2 (rt),
        .wa  (reg_wa),
        .wd  (reg_wd),
        .rd1 (rd_a),
        .rd2 (rd_b)
    );

    assign srca = ALUSrcA ? a : pc;

    always_comb begin
        srcb = b;
        case (srcb_e'(ALUSrcB))
            SRCB_REG:  srcb = b;
            SRCB_ONE:  srcb = {{(DATA_W-1){1'b0}}, 1'b1};
            SRCB_SIGN: srcb = sign_ext(imm);
            SRCB_ZERO: srcb = zero_ext(imm);
            default:   srcb = b;
        endcase
    end

    // Unassigned opcodes deliberately yield zero rather than a don't-care.
    always_comb begin
        alu_result = '0;
        case (alu_op_e'(ALUControl))
            ALU_AND: alu_result = srca & srcb;
            ALU_OR:  alu_result = srca | srcb;
            ALU_ADD: alu_result = srca + srcb;
            ALU_SUB: alu_result = srca - srcb;
            ALU_SLT: alu_result = {{(DATA_W-1){1'b0}}, ($signed(srca) < $signed(srcb))};
            default: alu_result = '0;
        endcase
    end

    assign Zero    = (alu_result == '0);
    assign pc_next = PCSrc ? aluout : alu_result;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc     <= '0;
            ir     <= '0;
            mdr    <= '0;
            a      <= '0;
            b      <= '0;
            aluout <= '0;
        end else begin
            if (PCEn) begin
                pc <= pc_next;
            end
            if (IRWrite) begin
                ir <= mem_rdata;
            end
            mdr    <= mem_rdata;
            a      <= rd_a;
            b      <= rd_b;
            aluout <= alu_result;
        end
    end

endmodule

// File: tb/tb_data_path.sv
// Directed bench for data_path: runs short multicycle instruction sequences from preloaded memory.
module tb_data_path;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       PCEn, IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA, PCSrc;
    logic [1:0] ALUSrcB;
    logic [2:0] ALUControl;
    logic [3:0] Opcode;
    logic [2:0] Funct;
    logic       Zero;

    int checks = 0;
    int errors = 0;

    data_path dut (
        .rst        (rst),
        .clk        (clk),
        .PCEn       (PCEn),
        .IorD       (IorD),
        .MemWrite   (MemWrite),
        .IRWrite    (IRWrite),
        .RegDst     (RegDst),
        .MemtoReg   (MemtoReg),
        .RegWrite   (RegWrite),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ALUControl (ALUControl),
        .PCSrc      (PCSrc),
        .Opcode     (Opcode),
        .Funct      (Funct),
        .Zero       (Zero)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic setControls(input logic pcen, input logic iord, input logic memwrite,
                               input logic irwrite, input logic regdst, input logic memtoreg,
                               input logic regwrite, input logic srca, input logic [1:0] srcb,
                               input logic [2:0] aluctl, input logic pcsrc);
        PCEn = pcen; IorD = iord; MemWrite = memwrite; IRWrite = irwrite;
        RegDst = regdst; MemtoReg = memtoreg; RegWrite = regwrite;
        ALUSrcA = srca; ALUSrcB = srcb; ALUControl = aluctl; PCSrc = pcsrc;
    endtask

    task automatic applyStimulus(input logic pcen, input logic iord, input logic memwrite,
                                 input logic irwrite, input logic regdst, input logic memtoreg,
                                 input logic regwrite, input logic srca, input logic [1:0] srcb,
                                 input logic [2:0] aluctl, input logic pcsrc);
        setControls(pcen, iord, memwrite, irwrite, regdst, memtoreg, regwrite, srca, srcb, aluctl, pcsrc);
        @(posedge clk);
        #1;
    endtask

    task automatic fetch();
        applyStimulus(1, 0, 0, 1, 0, 0, 0, 0, 2'b01, 3'b010, 0);
    endtask

    task automatic decode();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 3'b000, 0);
    endtask

    task automatic execute(input logic [1:0] srcb);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, srcb, 3'b010, 0);
    endtask

    task automatic memRead();
        applyStimulus(0, 1, 0, 0, 0, 0, 0, 0, 2'b00, 3'b000, 0);
    endtask

    task automatic writeBack(input logic regdst, input logic memtoreg);
        applyStimulus(0, 0, 0, 0, regdst, memtoreg, 1, 0, 2'b00, 3'b000, 0);
    endtask

    task automatic aluCheck(input string tag, input logic [2:0] aluctl,
                            input logic [15:0] expResult, input logic expZero);
        setControls(0, 0, 0, 0, 0, 0, 0, 1, 2'b00, aluctl, 0);
        #1;
        checkOutput(tag, dut.alu_result, expResult);
        checkOutput({tag, "_zero"}, {15'b0, Zero}, {15'b0, expZero});
    endtask

    initial begin
        setControls(0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 3'b000, 0);
        dut.mem[0]  = 16'h1234;
        dut.mem[1]  = 16'h2045;
        dut.mem[2]  = 16'h2087;
        dut.mem[3]  = 16'h029A;
        dut.mem[4]  = 16'h2149;
        dut.mem[5]  = 16'h0B40;
        dut.mem[6]  = 16'h21BF;
        dut.mem[7]  = 16'h21C1;
        dut.mem[8]  = 16'h0DC0;
        dut.mem[9]  = 16'h8160;
        dut.mem[10] = 16'h9579;
        dut.mem[11] = 16'h8539;
        dut.mem[12] = 16'h8021;
        dut.mem[32] = 16'hBEEF;
        dut.mem[33] = 16'h00FF;
        dut.mem[64] = 16'h5A5A;
        #1 rst = 1'b0;
        #1;
        checkOutput("reset_pc", dut.pc, 16'h0000);
        checkOutput("reset_opcode", {12'b0, Opcode}, 16'h0000);
        checkOutput("reset_funct", {13'b0, Funct}, 16'h0000);
        checkOutput("reset_zero", {15'b0, Zero}, 16'h0001);
        @(negedge clk);
        rst = 1'b1;

        fetch();
        checkOutput("fetch_ir", dut.ir, 16'h1234);
        checkOutput("fetch_pc", dut.pc, 16'h0001);
        checkOutput("fetch_opcode", {12'b0, Opcode}, 16'h0001);
        checkOutput("fetch_funct", {13'b0, Funct}, 16'h0004);

        fetch(); decode(); execute(2'b10); writeBack(0, 0);
        checkOutput("addi_r1", dut.u_reg_file.regs[1], 16'h0005);
        fetch(); decode(); execute(2'b10); writeBack(0, 0);
        checkOutput("addi_r2", dut.u_reg_file.regs[2], 16'h0007);

        fetch();
        checkOutput("rtype_funct", {13'b0, Funct}, 16'h0002);
        decode(); execute(2'b00); writeBack(1, 0);
        checkOutput("add_r3", dut.u_reg_file.regs[3], 16'h000C);

        fetch(); decode(); execute(2'b10); writeBack(0, 0);
        fetch(); decode();
        aluCheck("sub_equal", 3'b110, 16'h0000, 1'b1);
        aluCheck("add_nine", 3'b010, 16'h0012, 1'b0);

        fetch(); decode(); execute(2'b10); writeBack(0, 0);
        checkOutput("addi_sext_r6", dut.u_reg_file.regs[6], 16'hFFFF);
        fetch(); decode(); execute(2'b10); writeBack(0, 0);
        fetch(); decode();
        aluCheck("slt_neg", 3'b111, 16'h0001, 1'b0);
        aluCheck("and", 3'b000, 16'h0001, 1'b0);
        aluCheck("or", 3'b001, 16'hFFFF, 1'b0);
        aluCheck("add_wrap", 3'b010, 16'h0000, 1'b1);
        aluCheck("sub", 3'b110, 16'hFFFE, 1'b0);
        aluCheck("code011", 3'b011, 16'h0000, 1'b1);
        aluCheck("code101", 3'b101, 16'h0000, 1'b1);

        fetch(); decode(); execute(2'b11);
        checkOutput("zext_aluout", dut.aluout, 16'h0020);
        memRead(); writeBack(0, 1);
        checkOutput("lw_r5", dut.u_reg_file.regs[5], 16'hBEEF);

        fetch(); decode(); execute(2'b11);
        checkOutput("sw_addr", dut.aluout, 16'h0040);
        checkOutput("sw_b", dut.b, 16'hBEEF);
        applyStimulus(0, 1, 1, 1, 0, 0, 0, 0, 2'b00, 3'b000, 0);
        checkOutput("sw_mem64", dut.mem[64], 16'hBEEF);
        checkOutput("sw_ir_old", dut.ir, 16'h5A5A);
        checkOutput("sw_pc_hold", dut.pc, 16'h000B);

        fetch(); decode(); execute(2'b11); memRead();
        checkOutput("lw_mdr", dut.mdr, 16'hBEEF);
        writeBack(0, 1);
        checkOutput("lw_r4", dut.u_reg_file.regs[4], 16'hBEEF);

        fetch(); decode(); execute(2'b11); memRead();
        checkOutput("r0_mdr", dut.mdr, 16'h00FF);
        writeBack(0, 1);
        decode();
        checkOutput("r0_reads_zero", dut.a, 16'h0000);

        #2 rst = 1'b0;
        #1;
        checkOutput("async_pc", dut.pc, 16'h0000);
        checkOutput("async_ir", dut.ir, 16'h0000);
        checkOutput("async_r3", dut.u_reg_file.regs[3], 16'h0000);
        checkOutput("async_mem64", dut.mem[64], 16'hBEEF);
        checkOutput("async_zero", {15'b0, Zero}, 16'h0001);
        applyStimulus(1, 0, 1, 1, 0, 0, 1, 0, 2'b01, 3'b010, 0);
        checkOutput("held_mem0", dut.mem[0], 16'h1234);
        checkOutput("held_pc", dut.pc, 16'h0000);
        rst = 1'b1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/data_path.md
DATA_PATH -- requirements
Module: data_path

Interface
REQ-001 SHALL use one clock and an asynchronous, active-low reset: clk, rst.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  asynchronous, active-low reset (0 = reset).
REQ-004 PCEn  input  1  PC load enable; the controller has already combined branch and zero into it.
REQ-005 IorD  input  1  memory address select: 0 = PC, 1 = ALUOut.
REQ-006 MemWrite  input  1  memory write enable.
REQ-007 IRWrite  input  1  instruction register load enable.
REQ-008 RegDst  input  1  register write address select: 0 = rt, 1 = rd.
REQ-009 MemtoReg  input  1  register write data select: 0 = ALUOut, 1 = MDR.
REQ-010 RegWrite  input  1  register file write enable.
REQ-011 ALUSrcA  input  1  ALU operand A select: 0 = PC, 1 = A register.
REQ-012 ALUSrcB  input  2  ALU operand B select: 00 = B register, 01 = constant 1, 10 = SignImm, 11 = ZeroImm.
REQ-013 ALUControl  input  3  ALU operation code.
REQ-014 PCSrc  input  1  next-PC select: 0 = ALUResult (combinational), 1 = ALUOut.
REQ-015 Opcode  output  4  IR[15:12]; Funct  output  3  IR[2:0]; Zero  output  1  asserted when ALUResult equals 0.
REQ-016 Ports SHALL appear in this order: rst, clk, PCEn, IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA, ALUSrcB, ALUControl, PCSrc, Opcode, Funct, Zero.

Function
REQ-017 Data width SHALL be 16 bits and memory SHALL be word-addressed, so PC increments by 1.
REQ-018 Instruction fields SHALL be: op[15:12], rs[11:9], rt[8:6], rd[5:3], funct[2:0], imm[5:0].
REQ-019 SignImm SHALL be imm sign-extended to 16 bits; ZeroImm SHALL be imm zero-extended to 16 bits.
REQ-020 Memory SHALL be unified instruction/data, 256 x 16 bits, indexed by address[7:0] with the upper address bits ignored.
REQ-021 Memory read SHALL be combinational; memory write SHALL occur on the clk rising edge when MemWrite=1, writing the B register.
REQ-022 IR SHALL load the memory read data on the clk edge when IRWrite=1 and hold otherwise.
REQ-023 MDR, A, B and ALUOut SHALL load unconditionally on every clk edge.
REQ-024 Register file SHALL hold 8 x 16 bits, with two combinational reads (rs to A, rt to B) and one write on the clk edge.
REQ-025 Register R0 SHALL always read 0; writes to R0 SHALL be ignored.
REQ-026 A read of a register during the same cycle it is written SHALL return the old value (no bypass).
REQ-027 ALU codes: 000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT (signed compare, result 1 or 0); codes 011, 100, 101 SHALL produce 0.
REQ-028 ADD and SUB SHALL wrap modulo 2^16, with no overflow flag.
REQ-029 PC SHALL load the PCSrc-selected value on the clk edge when PCEn=1 and hold otherwise.
REQ-030 Simultaneous MemWrite and IRWrite with IorD=1 SHALL load IR with the old memory word at that address.

Reset
REQ-031 While rst=0, PC, IR, MDR, A, B, ALUOut and all register file entries SHALL be 0, asynchronously.
REQ-032 Memory contents SHALL NOT be affected by reset.
REQ-033 Consequently Opcode=0, Funct=0 and Zero=1 while reset is asserted with ALUSrcA=0 and ALUSrcB=00.
REQ-034 Reset asserted mid-instruction SHALL abandon that instruction; no pending write SHALL complete after reset asserts.

Structure
REQ-035 A shared package SHALL hold the ALUControl codes, the ALUSrcB select codes, and the width/depth constants (16, 8 registers, 256 words).
REQ-036 The register file SHALL be one sub-module named reg_file.
REQ-037 The ALU, memory, mux and pipeline registers SHALL be inline in data_path.
REQ-038 The memory array SHALL be named mem so a bench can preload it hierarchically.

Verification
REQ-039 Fetch: mem[0]=16'h1234; rst released; drive IorD=0, IRWrite=1, ALUSrcA=0, ALUSrcB=01, ALUControl=010, PCSrc=0, PCEn=1 for one edge -> IR=16'h1234, PC=1, Opcode=1, Funct=4.
REQ-040 R-type ADD: R1=5, R2=7 (preloaded via an ADD-immediate sequence), execute ALUSrcA=1, ALUSrcB=00, ALUControl=010, then RegDst=1, RegWrite=1 with rd=3 -> R3=12.
REQ-041 SUB/Zero/SLT: A=B=16'h0009 with ALUControl=110 -> Zero=1; A=16'hFFFF, B=1 with ALUControl=111 -> ALUResult=1.
REQ-042 Load/store: B=16'hBEEF, ALUOut=16'h0040, IorD=1, MemWrite=1 -> mem[64]=16'hBEEF; the next cycle MDR=16'hBEEF; MemtoReg=1, RegDst=0, RegWrite=1, rt=4 -> R4=16'hBEEF.
REQ-043 R0 and reset: RegWrite to R0 with 16'h00FF -> R0 still reads 0; assert rst=0 mid-cycle -> PC, IR and R3 read 0 immediately while mem[64] stays 16'hBEEF.
